// File: rtl/arith_array_rf_pkg.sv
// Shared types and helpers for the arithmetic-fill register array.
// The fill FSM states are defined here, along with the closed-form fill value.
package arith_array_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

  // Closed-form value of entry i after a fill. Callers truncate the result to their WIDTH.
  function automatic logic [63:0] fill_value(input logic [63:0] base,
                                             input logic [63:0] step,
                                             input int unsigned  i);
    return base + step * 64'(i);
  endfunction

endpackage

// File: rtl/arith_array_rf_if.sv
// Bus bundle for arith_array_rf: fill request/status, write port and two read ports.
// The master drives requests and indices. The slave (the array) drives status and read data.
interface arith_array_rf_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int IDX_W = $clog2(DEPTH);

  logic             fill_start;
  logic [WIDTH-1:0] fill_base;
  logic [WIDTH-1:0] fill_step;
  logic             fill_busy;
  logic             fill_done;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             wr_drop;

  logic [IDX_W-1:0] rd_a_idx;
  logic [IDX_W-1:0] rd_b_idx;
  logic [WIDTH-1:0] rd_a_data;
  logic [WIDTH-1:0] rd_b_data;

  modport master (
    output fill_start, fill_base, fill_step,
    output wr_en, wr_idx, wr_data,
    output rd_a_idx, rd_b_idx,
    input  fill_busy, fill_done, wr_drop,
    input  rd_a_data, rd_b_data
  );

  modport slave (
    input  fill_start, fill_base, fill_step,
    input  wr_en, wr_idx, wr_data,
    input  rd_a_idx, rd_b_idx,
    output fill_busy, fill_done, wr_drop,
    output rd_a_data, rd_b_data
  );

endinterface

// File: rtl/arith_array_rf_fill_seq.sv
// Arithmetic-fill sequencer: walks ptr over 0..DEPTH-1 and emits base + i*step, one entry per cycle.
// Busy and done are decoded directly from the state flop, so they are registered outputs.
module arith_fill_seq
  import arith_array_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fill_start,
  input  logic [WIDTH-1:0] fill_base,
  input  logic [WIDTH-1:0] fill_step,
  output logic             fill_busy,
  output logic             fill_done,
  output logic             fill_we,
  output logic [IDX_W-1:0] fill_idx,
  output logic [WIDTH-1:0] fill_data
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  fill_state_e      state_q, state_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0] step_q,  step_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;

  // NOTE: every signal written here gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    step_d  = step_q;
    ptr_d   = ptr_q;
    fill_we = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fill_start) begin
          state_d = FILL;
          acc_d   = fill_base;
          step_d  = fill_step;
          ptr_d   = '0;
        end
      end
      FILL: begin
        fill_we = 1'b1;
        acc_d   = acc_q + step_q;          // carry out is discarded: silent wrap
        ptr_d   = ptr_q + IDX_W'(1);
        if (ptr_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      step_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      ptr_q   <= ptr_d;
    end
  end

  assign fill_busy = (state_q == FILL);
  assign fill_done = (state_q == DONE);
  assign fill_idx  = ptr_q;
  assign fill_data = acc_q;

endmodule

// File: rtl/arith_array_rf.sv
// DEPTH x WIDTH flop array with an arithmetic-fill engine, one write port and two registered read ports.
// Reads sample the array before any same-edge write lands, so a read of the written index returns the old value.
module arith_array_rf
  import arith_array_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  arith_array_rf_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);

  logic             fill_we;
  logic [IDX_W-1:0] fill_idx;
  logic [WIDTH-1:0] fill_data;
  logic             fill_busy;

  arith_fill_seq #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fill_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .fill_start (bus.fill_start),
    .fill_base  (bus.fill_base),
    .fill_step  (bus.fill_step),
    .fill_busy  (fill_busy),
    .fill_done  (bus.fill_done),
    .fill_we    (fill_we),
    .fill_idx   (fill_idx),
    .fill_data  (fill_data)
  );

  assign bus.fill_busy = fill_busy;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd_a_data_q, rd_a_data_d;
  logic [WIDTH-1:0] rd_b_data_q, rd_b_data_d;
  logic             wr_drop_q,   wr_drop_d;

  // External writes are only rejected while the fill owns the array; DONE accepts them.
  always_comb begin
    mem_d = mem_q;
    if (fill_we) begin
      mem_d[fill_idx] = fill_data;
    end else if (bus.wr_en) begin
      mem_d[bus.wr_idx] = bus.wr_data;
    end
    wr_drop_d   = bus.wr_en & fill_busy;
    rd_a_data_d = mem_q[bus.rd_a_idx];
    rd_b_data_d = mem_q[bus.rd_b_idx];
  end

  // NOTE: the array is plain flops rather than a RAM macro, so clearing it on reset is both legal and intended.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q       <= '{default: '0};
      rd_a_data_q <= '0;
      rd_b_data_q <= '0;
      wr_drop_q   <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd_a_data_q <= rd_a_data_d;
      rd_b_data_q <= rd_b_data_d;
      wr_drop_q   <= wr_drop_d;
    end
  end

  assign bus.rd_a_data = rd_a_data_q;
  assign bus.rd_b_data = rd_b_data_q;
  assign bus.wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_arith_array_rf.sv
// Scoreboard bench for arith_array_rf: a DEPTH=4 and a DEPTH=8 instance share stimulus, one held in reset at a time.
// Stimulus pushes the expected post-edge outputs; a negedge monitor pops and compares them.
module tb_arith_array_rf;
  import arith_array_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n4, rst_n8;
  logic       fill_start;
  logic [7:0] fill_base, fill_step, wr_data;
  logic       wr_en;
  logic [2:0] wr_idx, rd_a_idx, rd_b_idx;

  arith_array_rf_if #(.WIDTH(8), .DEPTH(4)) bus4 ();
  arith_array_rf_if #(.WIDTH(8), .DEPTH(8)) bus8 ();

  assign bus4.fill_start = fill_start;
  assign bus4.fill_base  = fill_base;
  assign bus4.fill_step  = fill_step;
  assign bus4.wr_en      = wr_en;
  assign bus4.wr_idx     = wr_idx[1:0];
  assign bus4.wr_data    = wr_data;
  assign bus4.rd_a_idx   = rd_a_idx[1:0];
  assign bus4.rd_b_idx   = rd_b_idx[1:0];

  assign bus8.fill_start = fill_start;
  assign bus8.fill_base  = fill_base;
  assign bus8.fill_step  = fill_step;
  assign bus8.wr_en      = wr_en;
  assign bus8.wr_idx     = wr_idx;
  assign bus8.wr_data    = wr_data;
  assign bus8.rd_a_idx   = rd_a_idx;
  assign bus8.rd_b_idx   = rd_b_idx;

  arith_array_rf #(.WIDTH(8), .DEPTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n4), .bus(bus4));
  arith_array_rf #(.WIDTH(8), .DEPTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n8), .bus(bus8));

  typedef struct {
    int         due;
    bit         d8;
    string      name;
    bit         chk_rd;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic       drop;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  exp_t       mon_e;
  logic [7:0] got_a, got_b;
  logic       got_busy, got_done, got_drop;
  bit         ok;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e    = exp_q.pop_front();
      got_a    = mon_e.d8 ? bus8.rd_a_data : bus4.rd_a_data;
      got_b    = mon_e.d8 ? bus8.rd_b_data : bus4.rd_b_data;
      got_busy = mon_e.d8 ? bus8.fill_busy : bus4.fill_busy;
      got_done = mon_e.d8 ? bus8.fill_done : bus4.fill_done;
      got_drop = mon_e.d8 ? bus8.wr_drop   : bus4.wr_drop;
      ok = (got_busy === mon_e.busy) && (got_done === mon_e.done) && (got_drop === mon_e.drop);
      if (mon_e.chk_rd) ok = ok && (got_a === mon_e.a) && (got_b === mon_e.b);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL %s: got a=%h b=%h busy=%b done=%b drop=%b, expected a=%h b=%h busy=%b done=%b drop=%b",
                 mon_e.name, got_a, got_b, got_busy, got_done, got_drop,
                 mon_e.a, mon_e.b, mon_e.busy, mon_e.done, mon_e.drop);
      end
    end
  end

  task automatic drive(input bit fs, input logic [7:0] base, input logic [7:0] stp,
                       input bit we, input logic [2:0] wi, input logic [7:0] wd,
                       input logic [2:0] ra, input logic [2:0] rb);
    fill_start = fs;
    fill_base  = base;
    fill_step  = stp;
    wr_en      = we;
    wr_idx     = wi;
    wr_data    = wd;
    rd_a_idx   = ra;
    rd_b_idx   = rb;
  endtask

  task automatic idle(input logic [2:0] ra, input logic [2:0] rb);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00, ra, rb);
  endtask

  // Queue the outputs expected right after the next rising edge, then advance past that edge.
  task automatic step_exp(input string name, input bit d8, input bit chk_rd,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic busy, input logic done, input logic drop);
    exp_t e;
    e.due = cyc + 1; e.d8 = d8; e.name = name; e.chk_rd = chk_rd;
    e.a = a; e.b = b; e.busy = busy; e.done = done; e.drop = drop;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic step4(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic busy, input logic done, input logic drop);
    step_exp(name, 1'b0, 1'b1, a, b, busy, done, drop);
  endtask

  task automatic step8(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic busy, input logic done, input logic drop);
    step_exp(name, 1'b1, 1'b1, a, b, busy, done, drop);
  endtask

  function automatic logic [7:0] fv(input logic [7:0] base, input logic [7:0] stp, input int unsigned i);
    return 8'(fill_value(64'(base), 64'(stp), i));
  endfunction

  initial begin
    rst_n4 = 1'b0;
    rst_n8 = 1'b0;
    idle(3'd0, 3'd0);
    @(posedge clk);
    #1;

    // Reset state on the DEPTH=4 instance.
    idle(3'd0, 3'd0); step4("rst_hold0", 8'h00, 8'h00, 0, 0, 0);
    idle(3'd1, 3'd2); step4("rst_hold1", 8'h00, 8'h00, 0, 0, 0);
    rst_n4 = 1'b1;
    idle(3'd0, 3'd1); step4("rst_rd01", 8'h00, 8'h00, 0, 0, 0);
    idle(3'd2, 3'd3); step4("rst_rd23", 8'h00, 8'h00, 0, 0, 0);

    // Fill base 0x10 step 0x01; fill_start during FILL and DONE must be ignored.
    drive(1'b1, 8'h10, 8'h01, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0); step4("f1_start", 8'h00, 8'h00, 1, 0, 0);
    idle(3'd0, 3'd0); step4("f1_c1_rbw", 8'h00, 8'h00, 1, 0, 0);
    idle(3'd0, 3'd1); step4("f1_c2", 8'h10, 8'h00, 1, 0, 0);
    drive(1'b1, 8'h77, 8'h05, 1'b0, 3'd0, 8'h00, 3'd1, 3'd0); step4("f1_c3_ign", 8'h11, 8'h10, 1, 0, 0);
    idle(3'd2, 3'd3); step4("f1_done", 8'h12, 8'h00, 0, 1, 0);
    drive(1'b1, 8'h77, 8'h05, 1'b0, 3'd0, 8'h00, 3'd3, 3'd3); step4("f1_done_ign", 8'h13, 8'h13, 0, 0, 0);
    idle(3'd0, 3'd0); step4("f1_idle", 8'h10, 8'h10, 0, 0, 0);

    // Fill base 0xFE step 0x03 (wraps); a write during FILL is dropped, a write in DONE lands.
    drive(1'b1, 8'hFE, 8'h03, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0); step4("f2_start", 8'h10, 8'h10, 1, 0, 0);
    idle(3'd0, 3'd0); step4("f2_c1", 8'h10, 8'h10, 1, 0, 0);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 3'd2, 8'hAA, 3'd0, 3'd1); step4("f2_drop", 8'hFE, 8'h11, 1, 0, 1);
    idle(3'd2, 3'd2); step4("f2_c3", 8'h12, 8'h12, 1, 0, 0);
    idle(3'd2, 3'd1); step4("f2_done", 8'h04, 8'h01, 0, 1, 0);
    drive(1'b0, 8'h00, 8'h00, 1'b1, 3'd3, 8'h33, 3'd3, 3'd0); step4("f2_done_wr", 8'h07, 8'hFE, 0, 0, 0);
    idle(3'd2, 3'd3); step4("f2_keep_fill", 8'h04, 8'h33, 0, 0, 0);

    // The same write in IDLE is accepted.
    drive(1'b0, 8'h00, 8'h00, 1'b1, 3'd2, 8'hAA, 3'd0, 3'd0); step4("idle_wr2", 8'hFE, 8'hFE, 0, 0, 0);
    idle(3'd2, 3'd1); step4("idle_rd2", 8'hAA, 8'h01, 0, 0, 0);

    // Read-before-write on the same index, both ports.
    drive(1'b0, 8'h00, 8'h00, 1'b1, 3'd1, 8'h55, 3'd1, 3'd1); step4("rbw_old", 8'h01, 8'h01, 0, 0, 0);
    idle(3'd1, 3'd1); step4("rbw_new", 8'h55, 8'h55, 0, 0, 0);

    // fill_start with wr_en in one IDLE cycle: the write lands, then the fill overwrites it.
    drive(1'b1, 8'h00, 8'h20, 1'b1, 3'd0, 8'h99, 3'd0, 3'd0); step4("fs_wr_start", 8'hFE, 8'hFE, 1, 0, 0);
    idle(3'd0, 3'd0); step4("fs_wr_c1", 8'h99, 8'h99, 1, 0, 0);
    idle(3'd0, 3'd0); step4("fs_wr_c2", 8'h00, 8'h00, 1, 0, 0);
    idle(3'd1, 3'd2); step4("fs_wr_c3", 8'h20, 8'hAA, 1, 0, 0);
    idle(3'd2, 3'd3); step4("fs_wr_done", 8'h40, 8'h33, 0, 1, 0);
    idle(3'd3, 3'd0); step4("fs_wr_idle", 8'h60, 8'h00, 0, 0, 0);

    // DEPTH=8 instance: reset during the 3rd busy cycle, then a clean fill.
    rst_n4 = 1'b0;
    rst_n8 = 1'b1;
    idle(3'd0, 3'd1); step8("d8_rd", 8'h00, 8'h00, 0, 0, 0);
    drive(1'b1, 8'h10, 8'h10, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0); step8("d8_start", 8'h00, 8'h00, 1, 0, 0);
    idle(3'd0, 3'd0); step8("d8_c1", 8'h00, 8'h00, 1, 0, 0);
    idle(3'd0, 3'd1); step8("d8_c2", 8'h10, 8'h00, 1, 0, 0);
    rst_n8 = 1'b0;
    idle(3'd0, 3'd1); step8("d8_mid_rst", 8'h00, 8'h00, 0, 0, 0);
    rst_n8 = 1'b1;
    idle(3'd0, 3'd1); step8("d8_cleared01", 8'h00, 8'h00, 0, 0, 0);
    idle(3'd2, 3'd3); step8("d8_cleared23", 8'h00, 8'h00, 0, 0, 0);

    drive(1'b1, 8'h01, 8'h02, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0); step8("d8_f_start", 8'h00, 8'h00, 1, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      idle(3'((k >= 2) ? k - 2 : 0), 3'(k - 1));
      step8($sformatf("d8_f_c%0d", k), (k >= 2) ? fv(8'h01, 8'h02, k - 2) : 8'h00, 8'h00,
            (k < 8), (k == 8), 1'b0);
    end
    idle(3'd6, 3'd7); step8("d8_f_rd67", fv(8'h01, 8'h02, 6), fv(8'h01, 8'h02, 7), 0, 0, 0);
    idle(3'd4, 3'd4); step8("d8_f_rd44", 8'h09, 8'h09, 0, 0, 0);

    idle(3'd0, 3'd0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arith_array_rf.md
# arith_array_rf

Parametrised register array with a sequential arithmetic-fill engine, one write port and two independent registered read ports. It is the stateful, generalised successor of our combinational offset-array selector. Instead of recomputing `data + i` every cycle, it fills `DEPTH` entries with `base + i*step` over `DEPTH` cycles and then serves random-access reads. It sits in the V3DfgPeephole isolated-module set as a small clocked array/select stimulus block.

## Interface
Parameters:
- `WIDTH`, 8, entry width in bits (≥1)
- `DEPTH`, 4, entry count; power of two, ≥2
- `IDX_W`, `$clog2(DEPTH)`, index width (derived, not overridden)

Ports:
- `clk` in 1: single clock; all state updates on its rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `fill_start` in 1: request an arithmetic fill (sampled in IDLE only)
- `fill_base` in WIDTH: value for entry 0, sampled with `fill_start`
- `fill_step` in WIDTH: increment between entries, sampled with `fill_start`
- `fill_busy` out 1: high while the fill FSM is in FILL
- `fill_done` out 1: one-cycle pulse after the last entry is written
- `wr_en` in 1: single-entry write request
- `wr_idx` in IDX_W: write index
- `wr_data` in WIDTH: write data
- `wr_drop` out 1: one-cycle pulse when `wr_en` is rejected because a fill is active
- `rd_a_idx`, `rd_b_idx` in IDX_W: read indices, one per port
- `rd_a_data`, `rd_b_data` out WIDTH: registered read data

## Operation
- Storage: `DEPTH` × `WIDTH` flops. Reset clears every entry to 0.
- FSM states and transitions:
  - IDLE → FILL on `fill_start`. Latch `acc = fill_base`, `step = fill_step`, `ptr = 0`.
  - FILL, each cycle: write `mem[ptr] = acc`, then `acc += step` (mod 2^WIDTH, carry discarded) and `ptr += 1`.
  - FILL → DONE when `ptr == DEPTH-1` is written.
  - DONE → IDLE unconditionally. `fill_done` is high while in DONE.
- Fill arithmetic: entry i = `(fill_base + i*fill_step) mod 2^WIDTH`. Wrap-around is silent.
- `fill_start` in FILL or DONE is ignored. No queuing, no restart.
- Writes:
  - In IDLE or DONE, `wr_en` writes `mem[wr_idx] = wr_data`.
  - In FILL, `wr_en` is dropped, the array is unchanged, and `wr_drop` pulses for one cycle.
- `fill_start` and `wr_en` in the same IDLE cycle: the write is performed and the fill starts next cycle. The fill then overwrites that entry.
- Reads:
  - Both ports read every cycle, independently.
  - `rd_x_data <= mem[rd_x_idx]`.
  - `rd_a_idx == rd_b_idx` is legal; both ports return the same value.
- Read/write same index, same cycle: read returns the pre-write value (read-before-write). This also applies to the fill's write.
- Reset mid-fill: the next edge with `rst_n` low returns to IDLE. All outputs, `acc` and `ptr` go to 0 and the array is cleared. No `fill_done` is issued.
- Reset values: `fill_busy` 0, `fill_done` 0, `wr_drop` 0, `rd_a_data` 0, `rd_b_data` 0, state IDLE.

## Timing
- Read latency: 1 cycle from index to data.
- A write is visible to a read issued the cycle after the write.
- Fill: `fill_start` sampled at edge T.
  - `fill_busy` is high for cycles T+1 … T+DEPTH.
  - Entry i is written at edge T+1+i.
  - `fill_done` is high in cycle T+DEPTH+1.
  - A new `fill_start` is accepted at edge T+DEPTH+2 at the earliest.
- `wr_drop` is asserted in the cycle after the rejected `wr_en`.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Package `arith_array_pkg`: holds the `fill_state_e` enum (IDLE, FILL, DONE) and the helper `fill_value(base, step, i)` used by the testbench scoreboard.
- Sub-module `arith_fill_seq`:
  - Contents: FSM, `acc`, `ptr`, plus the `fill_busy`/`fill_done` outputs.
  - Outputs to the parent: `fill_we`, `fill_idx`, `fill_data`.
- The top level owns the array, the write arbitration and the two read registers.

## Test plan
- Reset, then read all indices on both ports → every read returns 0; every flag is 0.
- WIDTH=8, DEPTH=4, fill base 0x10, step 0x01 → `fill_busy` high for 4 cycles, then a `fill_done` pulse. Reads return 0x10, 0x11, 0x12, 0x13.
- WIDTH=8, DEPTH=4, fill base 0xFE, step 0x03 → entries 0xFE, 0x01, 0x04, 0x07 (wrap).
- `wr_en` idx 2 data 0xAA during FILL → `wr_drop` pulses and entry 2 holds the fill value. The same write in IDLE → entry 2 = 0xAA.
- Write idx 1 = 0x55 while both ports read idx 1 in the same cycle → old value returned. The next cycle returns 0x55 on both ports.
- DEPTH=8 fill with `rst_n` low at the 3rd busy cycle → all outputs 0 next cycle, array cleared, no `fill_done`. A new fill then completes normally.
